// File: rtl/rx_pkt_classifier_if.sv
// AXI-Stream beat bundle shared by the ingress and egress sides of the classifier.
interface rx_pkt_classifier_if #(
   parameter int unsigned P_DW = 64,
   parameter int unsigned P_KW = 8
);
   logic            tvalid;
   logic [P_DW-1:0] tdata;
   logic [P_KW-1:0] tkeep;
   logic            tlast;
   logic            tuser;
   logic            tready;

   // Source side drives the beat, sink side drives ready
   modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/rx_pkt_classifier.sv
// rx_pkt_classifier: buffers ingress packets, issues one dest-MAC lookup per
// header, pairs the in-order lookup results with their packets and forwards
// each packet with its outport/seek_flag held for the whole packet.
module rx_pkt_classifier #(
   parameter int unsigned P_DATA_DEPTH = 256,
   parameter int unsigned P_META_DEPTH = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_stat_rx_status,
   rx_pkt_classifier_if.slave         rx_axis,
   output logic [47:0]                o_check_mac,
   output logic [3:0]                 o_check_id,
   output logic                       o_check_valid,
   input  logic                       i_result_valid,
   input  logic [3:0]                 i_check_id,
   input  logic [2:0]                 i_outport,
   input  logic [1:0]                 i_seek_flag,
   rx_pkt_classifier_if.master        tx_axis,
   output logic [2:0]                 o_meta_outport,
   output logic [1:0]                 o_meta_seek_flag,
   output logic                       o_err,
   output logic [15:0]                o_pkt_in_cnt,
   output logic [15:0]                o_pkt_out_cnt
);

   localparam int unsigned DATA_W = 64;
   localparam int unsigned KEEP_W = 8;
   localparam int unsigned BEAT_W = DATA_W + KEEP_W + 2;
   localparam int unsigned META_W = 5;
   localparam int unsigned DA_W   = $clog2(P_DATA_DEPTH);
   localparam int unsigned DC_W   = DA_W + 1;
   localparam int unsigned MA_W   = $clog2(P_META_DEPTH);
   localparam int unsigned MC_W   = MA_W + 1;
   localparam int unsigned CNT_W  = MA_W + 1;

   // Beat layout inside the data FIFO
   localparam int unsigned B_LAST = BEAT_W - 1;
   localparam int unsigned B_USER = BEAT_W - 2;

   typedef enum logic {IN_HEAD,  IN_BODY}  in_state_t;
   typedef enum logic {OUT_IDLE, OUT_SEND} out_state_t;

   in_state_t         in_state;
   out_state_t        out_state;
   logic              run;

   logic [BEAT_W-1:0] data_mem [P_DATA_DEPTH];
   logic [DC_W-1:0]   data_wr;
   logic [DC_W-1:0]   data_rd;
   logic [DC_W-1:0]   data_cnt;
   logic              data_full;
   logic              data_empty;
   logic              data_push;
   logic              data_pop;
   logic [BEAT_W-1:0] data_head;

   logic [META_W-1:0] meta_mem [P_META_DEPTH];
   logic [MC_W-1:0]   meta_wr;
   logic [MC_W-1:0]   meta_rd;
   logic              meta_empty;
   logic              meta_push;
   logic              meta_pop;
   logic [META_W-1:0] meta_head;

   logic [CNT_W-1:0]  resident;
   logic [CNT_W-1:0]  outstanding;
   logic [3:0]        tag;
   logic [3:0]        exp_tag;

   logic              rx_ready_c;
   logic              tx_valid_c;
   logic              hdr_acc;
   logic              tail_sent;
   logic              res_ok;

   // FIFO status and handshake decode
   always_comb begin
      data_cnt   = data_wr - data_rd;
      data_full  = (data_cnt == DC_W'(P_DATA_DEPTH));
      data_empty = (data_wr == data_rd);
      data_head  = data_mem[data_rd[DA_W-1:0]];
      meta_empty = (meta_wr == meta_rd);
      meta_head  = meta_mem[meta_rd[MA_W-1:0]];

      // Link status and resident limit only gate the start of a packet
      rx_ready_c = 1'b0;
      if (run && !data_full) begin
         if (in_state == IN_BODY) begin
            rx_ready_c = 1'b1;
         end else begin
            rx_ready_c = (resident < CNT_W'(P_META_DEPTH)) && i_stat_rx_status;
         end
      end

      data_push = rx_axis.tvalid && rx_ready_c;
      hdr_acc   = data_push && (in_state == IN_HEAD);
      tx_valid_c = (out_state == OUT_SEND) && !data_empty;
      data_pop  = tx_valid_c && tx_axis.tready;
      tail_sent = data_pop && data_head[B_LAST];
      meta_pop  = (out_state == OUT_IDLE) && !meta_empty;
      res_ok    = i_result_valid && (outstanding != '0);
      meta_push = res_ok;
   end

   assign rx_axis.tready = rx_ready_c;

   // Egress beat fields straight from the FIFO head, zero while idle
   assign tx_axis.tvalid = tx_valid_c;
   assign tx_axis.tdata  = tx_valid_c ? data_head[DATA_W-1:0]      : '0;
   assign tx_axis.tkeep  = tx_valid_c ? data_head[DATA_W +: KEEP_W] : '0;
   assign tx_axis.tuser  = tx_valid_c && data_head[B_USER];
   assign tx_axis.tlast  = tx_valid_c && data_head[B_LAST];

   // Hold ingress closed until the first clock after reset release
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         run <= 1'b0;
      end else begin
         run <= 1'b1;
      end
   end

   // Data FIFO storage: {tlast, tuser, tkeep, tdata}
   always_ff @(posedge i_clk) begin
      if (data_push) begin
         data_mem[data_wr[DA_W-1:0]] <= {rx_axis.tlast, rx_axis.tuser,
                                         rx_axis.tkeep, rx_axis.tdata};
      end
   end

   // Data FIFO pointers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         data_wr <= '0;
         data_rd <= '0;
      end else begin
         if (data_push) begin
            data_wr <= data_wr + DC_W'(1);
         end
         if (data_pop) begin
            data_rd <= data_rd + DC_W'(1);
         end
      end
   end

   // Meta FIFO storage: {outport, seek_flag}
   always_ff @(posedge i_clk) begin
      if (meta_push) begin
         meta_mem[meta_wr[MA_W-1:0]] <= {i_outport, i_seek_flag};
      end
   end

   // Meta FIFO pointers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         meta_wr <= '0;
         meta_rd <= '0;
      end else begin
         if (meta_push) begin
            meta_wr <= meta_wr + MC_W'(1);
         end
         if (meta_pop) begin
            meta_rd <= meta_rd + MC_W'(1);
         end
      end
   end

   // Input FSM, lookup request issue and ingress packet count
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         in_state      <= IN_HEAD;
         o_check_valid <= 1'b0;
         o_check_mac   <= '0;
         o_check_id    <= '0;
         tag           <= '0;
         o_pkt_in_cnt  <= '0;
      end else begin
         o_check_valid <= hdr_acc;
         if (hdr_acc) begin
            o_check_mac  <= rx_axis.tdata[63:16];
            o_check_id   <= tag;
            tag          <= tag + 4'd1;
            o_pkt_in_cnt <= o_pkt_in_cnt + 16'd1;
         end
         if (data_push) begin
            unique case (in_state)
               IN_HEAD: if (!rx_axis.tlast) in_state <= IN_BODY;
               IN_BODY: if (rx_axis.tlast)  in_state <= IN_HEAD;
            endcase
         end
      end
   end

   // Outstanding lookups, expected result tag and sticky protocol error
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         outstanding <= '0;
         exp_tag     <= '0;
         o_err       <= 1'b0;
      end else begin
         if (i_result_valid && ((outstanding == '0) || (i_check_id != exp_tag))) begin
            o_err <= 1'b1;
         end
         if (res_ok) begin
            exp_tag <= exp_tag + 4'd1;
         end
         case ({hdr_acc, res_ok})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Resident packets: header accepted but tlast not yet sent
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         resident <= '0;
      end else begin
         case ({hdr_acc, tail_sent})
            2'b10:   resident <= resident + CNT_W'(1);
            2'b01:   resident <= resident - CNT_W'(1);
            default: resident <= resident;
         endcase
      end
   end

   // Output FSM: latch metadata on pop, release it on the tlast handshake
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         out_state        <= OUT_IDLE;
         o_meta_outport   <= '0;
         o_meta_seek_flag <= '0;
         o_pkt_out_cnt    <= '0;
      end else begin
         unique case (out_state)
            OUT_IDLE: begin
               if (!meta_empty) begin
                  o_meta_outport   <= meta_head[META_W-1:2];
                  o_meta_seek_flag <= meta_head[1:0];
                  out_state        <= OUT_SEND;
               end
            end
            OUT_SEND: begin
               if (tail_sent) begin
                  o_pkt_out_cnt <= o_pkt_out_cnt + 16'd1;
                  out_state     <= OUT_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_pkt_classifier.sv
// Directed scoreboard bench for rx_pkt_classifier: beats, lookup requests and
// metadata are queued as stimulus is driven and compared as the DUT emits them.
module tb_rx_pkt_classifier;

   typedef struct packed {
      logic        last;
      logic        user;
      logic [7:0]  keep;
      logic [63:0] data;
   } beat_t;

   typedef struct packed {
      logic [47:0] mac;
      logic [3:0]  id;
      logic [3:0]  rid;
      logic [2:0]  port;
      logic [1:0]  flag;
   } req_t;

   typedef struct packed {
      logic [31:0] due;
      logic [3:0]  id;
      logic [2:0]  port;
      logic [1:0]  flag;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        status;
   logic [47:0] check_mac;
   logic [3:0]  check_id;
   logic        check_valid;
   logic        result_valid = 1'b0;
   logic [3:0]  res_id = '0;
   logic [2:0]  res_port = '0;
   logic [1:0]  res_flag = '0;
   logic [2:0]  meta_outport;
   logic [1:0]  meta_seek;
   logic        err;
   logic [15:0] in_cnt;
   logic [15:0] out_cnt;

   rx_pkt_classifier_if rx_axis ();
   rx_pkt_classifier_if tx_axis ();

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat = 2;
   int          tx_mode = 0;
   int          pkt_seq = 0;
   logic [3:0]  tb_tag = '0;

   beat_t       exp_beat_q[$];
   logic [4:0]  exp_meta_q[$];
   req_t        exp_req_q[$];
   resp_t       pend_q[$];

   always #5 clk = ~clk;

   rx_pkt_classifier dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_stat_rx_status (status),
      .rx_axis          (rx_axis.slave),
      .o_check_mac      (check_mac),
      .o_check_id       (check_id),
      .o_check_valid    (check_valid),
      .i_result_valid   (result_valid),
      .i_check_id       (res_id),
      .i_outport        (res_port),
      .i_seek_flag      (res_flag),
      .tx_axis          (tx_axis.master),
      .o_meta_outport   (meta_outport),
      .o_meta_seek_flag (meta_seek),
      .o_err            (err),
      .o_pkt_in_cnt     (in_cnt),
      .o_pkt_out_cnt    (out_cnt)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t mk_beat(input logic [47:0] mac, input int b, input int n,
                                     input logic [15:0] seq);
      beat_t r;
      r.data = (b == 0) ? {mac, mac[47:32]} : {seq, 16'(b), ~seq, 16'(n)};
      r.last = (b == n - 1);
      r.keep = r.last ? 8'h0F : 8'hFF;
      r.user = r.last & seq[0];
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Egress ready pattern: 0 = always, 1 = toggle, 2 = stalled
   always @(posedge clk) begin
      #1;
      case (tx_mode)
         0:       tx_axis.tready = 1'b1;
         1:       tx_axis.tready = cyc[0];
         default: tx_axis.tready = 1'b0;
      endcase
   end

   // Lookup model: check each request, answer after lat cycles in order
   always @(negedge clk) begin
      req_t rq;
      if (rst === 1'b0 && check_valid === 1'b1) begin
         if (exp_req_q.size() == 0) begin
            chk("check_valid_extra", 128'(1), 128'(0));
         end else begin
            rq = exp_req_q.pop_front();
            chk("check_mac", 128'(check_mac), 128'(rq.mac));
            chk("check_id", 128'(check_id), 128'(rq.id));
            pend_q.push_back('{due: 32'(cyc + lat), id: rq.rid, port: rq.port, flag: rq.flag});
         end
      end
   end

   always @(posedge clk) begin
      resp_t r;
      #1;
      result_valid = 1'b0;
      if (rst === 1'b0 && pend_q.size() > 0 && int'(pend_q[0].due) <= cyc) begin
         r = pend_q.pop_front();
         result_valid = 1'b1;
         res_id       = r.id;
         res_port     = r.port;
         res_flag     = r.flag;
      end
   end

   // Egress monitor: beat order, stall hold and per-packet metadata
   logic  prev_stall = 1'b0;
   beat_t prev_beat  = '0;
   always @(negedge clk) begin
      beat_t ob;
      beat_t e;
      ob = {tx_axis.tlast, tx_axis.tuser, tx_axis.tkeep, tx_axis.tdata};
      if (rst !== 1'b0) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("tvalid_held", 128'(tx_axis.tvalid), 128'(1));
            chk("stall_beat", 128'(ob), 128'(prev_beat));
         end
         if (tx_axis.tvalid === 1'b1 && tx_axis.tready === 1'b1) begin
            if (exp_beat_q.size() == 0) begin
               chk("egress_extra", 128'(1), 128'(0));
            end else begin
               e = exp_beat_q.pop_front();
               chk("egress_beat", 128'(ob), 128'(e));
               if (exp_meta_q.size() == 0) begin
                  chk("meta_missing", 128'(1), 128'(0));
               end else begin
                  chk("meta", 128'({meta_outport, meta_seek}), 128'(exp_meta_q[0]));
                  if (e.last) void'(exp_meta_q.pop_front());
               end
            end
         end
         prev_stall = (tx_axis.tvalid === 1'b1) && (tx_axis.tready !== 1'b1);
         prev_beat  = ob;
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input beat_t b);
      rx_axis.tvalid = 1'b1;
      rx_axis.tdata  = b.data;
      rx_axis.tkeep  = b.keep;
      rx_axis.tlast  = b.last;
      rx_axis.tuser  = b.user;
   endtask

   // Entered and left just after a rising edge
   task automatic send_beat(input beat_t b);
      bit done = 1'b0;
      drive(b);
      for (int t = 0; t < 400 && !done; t++) begin
         @(negedge clk);
         if (rx_axis.tready === 1'b1) done = 1'b1;
         sync();
      end
      if (!done) chk("ingress_timeout", 128'(0), 128'(1));
   endtask

   task automatic send_pkt(input logic [47:0] mac, input int n, input logic [2:0] port,
                           input logic [1:0] flag, input bit bad, input int drop_at);
      beat_t b;
      exp_req_q.push_back('{mac: mac, id: tb_tag, rid: bad ? tb_tag + 4'd5 : tb_tag,
                            port: port, flag: flag});
      exp_meta_q.push_back({port, flag});
      tb_tag = tb_tag + 4'd1;
      for (int i = 0; i < n; i++) begin
         b = mk_beat(mac, i, n, 16'(pkt_seq));
         exp_beat_q.push_back(b);
         send_beat(b);
         if (i == drop_at) status = 1'b0;
      end
      pkt_seq++;
      rx_axis.tvalid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int i = 0;
      while ((exp_beat_q.size() != 0 || exp_meta_q.size() != 0 || pend_q.size() != 0)
             && i < 3000) begin
         @(negedge clk);
         i++;
      end
      repeat (3) @(negedge clk);
      chk(tag, 128'(exp_beat_q.size() + exp_meta_q.size()), 128'(0));
      sync();
   endtask

   // Header presented while it must be held off
   task automatic hold_off(input string tag, input logic [47:0] mac);
      drive(mk_beat(mac, 0, 2, 16'(pkt_seq)));
      repeat (6) begin
         @(negedge clk);
         chk(tag, 128'(rx_axis.tready), 128'(0));
      end
      sync();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      status = 1'b1;
      rx_axis.tvalid = 1'b0;
      rx_axis.tdata  = '0;
      rx_axis.tkeep  = '0;
      rx_axis.tlast  = 1'b0;
      rx_axis.tuser  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rx_tready", 128'(rx_axis.tready), 128'(0));
      chk("rst_tx_tvalid", 128'(tx_axis.tvalid), 128'(0));
      chk("rst_tx_tdata", 128'(tx_axis.tdata), 128'(0));
      chk("rst_check_valid", 128'(check_valid), 128'(0));
      chk("rst_check_mac", 128'({check_mac, check_id}), 128'(0));
      chk("rst_meta", 128'({meta_outport, meta_seek}), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      chk("rst_cnts", 128'({in_cnt, out_cnt}), 128'(0));
      sync();
      rst = 1'b0;
      sync();

      // One long packet, free-running egress
      send_pkt(48'h8DBC5C4A0302, 128, 3'd3, 2'd0, 1'b0, -1);
      wait_drain("s1_drain");
      chk("s1_in_cnt", 128'(in_cnt), 128'(1));
      chk("s1_out_cnt", 128'(out_cnt), 128'(1));

      // Same packet with toggling egress ready
      tx_mode = 1;
      send_pkt(48'h8DBC5C4A0302, 128, 3'd3, 2'd0, 1'b0, -1);
      wait_drain("s2_drain");
      tx_mode = 0;

      // 17 back-to-back packets, tags wrap through 15 -> 0
      for (int p = 0; p < 17; p++) begin
         send_pkt(48'h020000000000 + 48'(p), 2, 3'(p), 2'(p), 1'b0, -1);
      end
      wait_drain("s3_drain");
      chk("s3_err", 128'(err), 128'(0));
      chk("s3_cnts", 128'({in_cnt, out_cnt}), 128'({16'd19, 16'd19}));

      // Stalled egress: eight packets resident, ninth header held off
      tx_mode = 2;
      for (int p = 0; p < 8; p++) begin
         send_pkt(48'h0A0000000000 + 48'(p), 2, 3'(7 - p), 2'(p + 1), 1'b0, -1);
      end
      repeat (6) sync();
      chk("s4_in_cnt", 128'(in_cnt), 128'(27));
      hold_off("s4_head_stall", 48'h0A00000000FF);
      tx_mode = 0;
      send_pkt(48'h0A00000000FF, 2, 3'd2, 2'd3, 1'b0, -1);
      wait_drain("s4_drain");
      chk("s4_cnts", 128'({in_cnt, out_cnt}), 128'({16'd28, 16'd28}));

      // Link drops mid-packet: packet completes, next header waits
      send_pkt(48'h0B0000000001, 6, 3'd6, 2'd1, 1'b0, 2);
      hold_off("s5_status_stall", 48'h0B0000000002);
      status = 1'b1;
      send_pkt(48'h0B0000000002, 3, 3'd4, 2'd2, 1'b0, -1);
      wait_drain("s5_drain");
      chk("s5_err", 128'(err), 128'(0));

      // Wrong returned tag: error flagged, packet still forwarded
      send_pkt(48'h0C0000000001, 4, 3'd5, 2'd2, 1'b1, -1);
      wait_drain("s6_bad_id_drain");
      chk("s6_bad_id_err", 128'(err), 128'(1));

      // Reset, then a spurious result with nothing outstanding
      rst = 1'b1;
      tb_tag = '0;
      repeat (2) @(negedge clk);
      chk("s6_rst_err", 128'(err), 128'(0));
      chk("s6_rst_cnts", 128'({in_cnt, out_cnt}), 128'(0));
      sync();
      rst = 1'b0;
      sync();
      pend_q.push_back('{due: 32'(cyc + 1), id: 4'd0, port: 3'd7, flag: 2'd3});
      repeat (5) @(negedge clk);
      chk("s6_spurious_err", 128'(err), 128'(1));
      chk("s6_spurious_tvalid", 128'(tx_axis.tvalid), 128'(0));
      sync();
      send_pkt(48'h0D0000000001, 2, 3'd1, 2'd1, 1'b0, -1);
      wait_drain("s6_after_spurious_drain");
      chk("s6_err_sticky", 128'(err), 128'(1));
      chk("s6_cnts", 128'({in_cnt, out_cnt}), 128'({16'd1, 16'd1}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
